// File: rtl/enigma_pkg.sv
// enigma_pkg: shared widths, ASCII bounds and character-class helpers for the Enigma key sequencer.
package enigma_pkg;
  localparam int CHAR_W = 8;
  localparam int SETTING_W = 2;
  localparam logic [CHAR_W-1:0] ASCII_A = 8'h41;
  localparam logic [CHAR_W-1:0] ASCII_Z = 8'h5A;
  localparam logic [CHAR_W-1:0] ASCII_LA = 8'h61;
  localparam logic [CHAR_W-1:0] ASCII_LZ = 8'h7A;
  typedef logic [SETTING_W-1:0] setting_t;
  function automatic logic is_upper(input logic [CHAR_W-1:0] c);
    return c >= ASCII_A && c <= ASCII_Z;
  endfunction
  function automatic logic is_lower(input logic [CHAR_W-1:0] c);
    return c >= ASCII_LA && c <= ASCII_LZ;
  endfunction
endpackage

// File: rtl/enigma_out_reg.sv
// enigma_out_reg: 1-deep valid/ready output register holding the mapped character.
module enigma_out_reg
  import enigma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [CHAR_W-1:0] d,
  output logic              s_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CHAR_W-1:0] m_char
);
  assign s_ready = !m_valid || m_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_char <= '0;
    end else if (s_valid && s_ready) begin
      m_valid <= 1'b1;
      m_char <= d;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
endmodule

// File: rtl/enigma_key_sequencer.sv
// enigma_key_sequencer: feeds the Enigma mapper with a rotating key digit per letter and registers its result.
// Optional ENIGMA_LOWERCASE_FOLD_EN: fold 'a'..'z' to uppercase and treat them as letters.
module enigma_key_sequencer
  import enigma_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int KEY_DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SETTING_W*KEY_DIGITS-1:0] key_in,
  input  logic                          key_load,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [CHAR_W-1:0]             s_char,
  output logic [CHAR_W-1:0]             map_char,
  output logic [SETTING_W-1:0]          map_setting,
  input  logic [CHAR_W-1:0]             map_out,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CHAR_W-1:0]             m_char,
  output logic [CNT_W-1:0]              char_count
);
  localparam int IDX_W = KEY_DIGITS > 1 ? $clog2(KEY_DIGITS) : 1;
  logic [SETTING_W*KEY_DIGITS-1:0] key_reg;
  logic [IDX_W-1:0] idx;
  logic letter, accept, step;
  setting_t cur_digit;
`ifdef ENIGMA_LOWERCASE_FOLD_EN
  assign map_char = is_lower(s_char) ? (s_char & 8'hDF) : s_char;
`else
  assign map_char = s_char;
`endif
  assign letter = is_upper(map_char);
  assign accept = s_valid && s_ready;
  assign step = accept && letter;
  // digit 0 sits in the MS bits of the key
  always_comb cur_digit = key_reg[SETTING_W*(KEY_DIGITS-1-int'(idx)) +: SETTING_W];
  assign map_setting = key_load ? key_in[SETTING_W*KEY_DIGITS-1 -: SETTING_W] : cur_digit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      key_reg <= '0;
      idx <= '0;
      char_count <= '0;
    end else if (key_load) begin
      key_reg <= key_in;
      idx <= IDX_W'(KEY_DIGITS > 1 && step);
      char_count <= CNT_W'(step);
    end else if (step) begin
      idx <= idx == IDX_W'(KEY_DIGITS-1) ? '0 : idx + 1'b1;
      char_count <= &char_count ? char_count : char_count + 1'b1;
    end
  enigma_out_reg u_out (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .d(letter ? map_out : s_char),
    .s_ready(s_ready),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_char(m_char)
  );
endmodule

// File: tb/tb_enigma_key_sequencer.sv
// tb_enigma_key_sequencer: randomized self-checking bench with a sequence-level key/mapper reference model.
module tb_enigma_key_sequencer;
  logic clk = 0, rst_n = 0, key_load = 0, s_valid = 0, m_ready = 0;
  logic [7:0] key_in = 0, s_char = 0, map_char, map_out, m_char;
  logic [1:0] map_setting;
  logic s_ready, m_valid;
  logic [15:0] char_count;
  int errors = 0, checks = 0;
  int tbl[4][26];
  int m_key[4];
  int m_idx, m_cnt, ncyc, proto_err;
  logic [7:0] exp_q[$], got_q[$];
  int exp_set[$], set_q[$];
  localparam logic [7:0] K1 = 8'b10_01_00_11, K2 = 8'b01_10_11_00;

  always #5 clk = ~clk;

  enigma_key_sequencer dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .s_valid(s_valid), .s_ready(s_ready), .s_char(s_char),
    .map_char(map_char), .map_setting(map_setting), .map_out(map_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_char(m_char), .char_count(char_count)
  );

  // bench mapper: per-setting letter involution, '?' for anything else
  always_comb map_out = (map_char >= 8'h41 && map_char <= 8'h5A) ?
    8'(65 + tbl[map_setting][int'(map_char) - 65]) : 8'h3F;

  task automatic build_tbl;
    string pr[4];
    pr[0] = "LYOA"; pr[1] = "ESWKDC"; pr[2] = "HCOGLD"; pr[3] = "LQRH";
    for (int s = 0; s < 4; s++) begin
      int pend = -1;
      for (int a = 0; a < 26; a++) tbl[s][a] = -1;
      for (int p = 0; p < pr[s].len(); p += 2) begin
        int a = int'(pr[s][p]) - 65, b = int'(pr[s][p+1]) - 65;
        tbl[s][a] = b; tbl[s][b] = a;
      end
      for (int a = 0; a < 26; a++)
        if (tbl[s][a] < 0) begin
          if (pend < 0) pend = a;
          else begin tbl[s][a] = pend; tbl[s][pend] = a; pend = -1; end
        end
    end
  endtask

  function automatic int fold(input int c);
`ifdef ENIGMA_LOWERCASE_FOLD_EN
    if (c >= 97 && c <= 122) return c - 32;
`endif
    return c;
  endfunction

  task automatic model_load(input logic [7:0] k);
    for (int d = 0; d < 4; d++) m_key[d] = (int'(k) >> (2 * (3 - d))) & 3;
    m_idx = 0; m_cnt = 0;
  endtask

  task automatic predict(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int c = fold(int'(s[i]));
      if (c >= 65 && c <= 90) begin
        exp_set.push_back(m_key[m_idx]);
        exp_q.push_back(8'(65 + tbl[m_key[m_idx]][c - 65]));
        m_idx = (m_idx + 1) % 4;
        if (m_cnt < 65535) m_cnt++;
      end else exp_q.push_back(s[i]);
    end
  endtask

  task automatic do_key_load(input logic [7:0] k);
    key_in = k; key_load = 1;
    @(posedge clk); @(negedge clk);
    key_load = 0;
    model_load(k);
    exp_q.delete(); exp_set.delete();
  endtask

  // drives s, draining the output register; records what comes out and the settings used
  task automatic run_stream(input string s, input int rdy_pct);
    int i = 0;
    ncyc = 0; got_q.delete(); set_q.delete();
    while ((i < s.len() || m_valid) && ncyc < 2000) begin
      logic acc;
      s_valid = i < s.len();
      s_char = s_valid ? s[i] : 8'h00;
      m_ready = $urandom_range(99) < rdy_pct;
      #1;
      if (s_ready !== (!m_valid || m_ready)) proto_err++;
      acc = s_valid && s_ready;
      if (acc && fold(int'(s[i])) >= 65 && fold(int'(s[i])) <= 90) set_q.push_back(int'(map_setting));
      if (m_valid && m_ready) got_q.push_back(m_char);
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      ncyc++;
    end
    s_valid = 0; m_ready = 0;
    if (ncyc >= 2000) begin
      checks++; errors++;
      $display("FAIL stream_timeout got=%0d cycles required<2000", ncyc);
    end
  endtask

  task automatic test_reset;
    #7;
    checks += 4;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    if (m_char !== 8'h00) begin errors++; $display("FAIL rst_m_char got=%h exp=00", m_char); end
    if (char_count !== 16'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", char_count); end
    if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_encrypt;
    string e = "CSYQGKAHDC", st = "2103210321";
    do_key_load(K1);
    run_stream("HELLOWORLD", 100);
    for (int i = 0; i < 10; i++) begin
      checks += 2;
      if (i >= got_q.size() || got_q[i] !== e[i]) begin errors++; $display("FAIL enc_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, e[i]); end
      if (i >= set_q.size() || set_q[i] != int'(st[i]) - 48) begin errors++; $display("FAIL enc_setting[%0d] got=%0d exp=%0d", i, i < set_q.size() ? set_q[i] : -1, int'(st[i]) - 48); end
    end
    checks += 2;
    if (char_count !== 16'd10) begin errors++; $display("FAIL enc_count got=%0d exp=10", char_count); end
    if (ncyc != 11) begin errors++; $display("FAIL enc_latency got=%0d cycles exp=11", ncyc); end
  endtask

  task automatic test_decrypt;
    string e = "HELLOWORLD";
    do_key_load(K1);
    run_stream("CSYQGKAHDC", 100);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) begin errors++; $display("FAIL dec_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, e[i]); end
    end
    checks++;
    if (char_count !== 16'd10) begin errors++; $display("FAIL dec_count got=%0d exp=10", char_count); end
  endtask

  task automatic test_back_pressure;
    string e = "CSYQGKAHDC";
    do_key_load(K1);
    s_valid = 1; s_char = "H"; m_ready = 1;
    @(posedge clk); @(negedge clk);
    s_char = "E"; m_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks += 4;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got=%b exp=0", s_ready); end
      if (m_char !== 8'h43 || m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_char got=%h/%b exp=43/1", m_char, m_valid); end
      if (map_setting !== 2'd1) begin errors++; $display("FAIL bp_setting got=%0d exp=1", map_setting); end
      if (char_count !== 16'd1) begin errors++; $display("FAIL bp_count got=%0d exp=1", char_count); end
      @(posedge clk); @(negedge clk);
    end
    run_stream("ELLOWORLD", 100);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) begin errors++; $display("FAIL bp_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, e[i]); end
    end
    checks++;
    if (char_count !== 16'd10) begin errors++; $display("FAIL bp_final_count got=%0d exp=10", char_count); end
  endtask

  task automatic test_nonletter;
    string st = "21032";
    do_key_load(K1);
    predict("HE LLO");
    run_stream("HE LLO", 100);
    checks++;
    if (got_q.size() > 2 && got_q[2] !== 8'h20) begin errors++; $display("FAIL nl_space got=%h exp=20", got_q[2]); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL nl_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, exp_q[i]); end
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= set_q.size() || set_q[i] != int'(st[i]) - 48) begin errors++; $display("FAIL nl_setting[%0d] got=%0d exp=%0d", i, i < set_q.size() ? set_q[i] : -1, int'(st[i]) - 48); end
    end
    checks++;
    if (char_count !== 16'd5) begin errors++; $display("FAIL nl_count got=%0d exp=5", char_count); end
  endtask

  task automatic test_keyload_mid;
    logic [7:0] held;
    do_key_load(K1);
    run_stream("HEL", 100);
    s_valid = 1; s_char = "L"; m_ready = 1; key_in = K2; key_load = 1;
    #1;
    checks++;
    if (map_setting !== 2'd1) begin errors++; $display("FAIL kl_setting got=%0d exp=1", map_setting); end
    @(posedge clk); @(negedge clk);
    key_load = 0; s_valid = 0;
    model_load(K2); exp_q.delete(); exp_set.delete();
    predict("LO");
    checks += 2;
    if (m_char !== exp_q[0] || m_valid !== 1'b1) begin errors++; $display("FAIL kl_char got=%h/%b exp=%h/1", m_char, m_valid, exp_q[0]); end
    if (char_count !== 16'd1) begin errors++; $display("FAIL kl_count got=%0d exp=1", char_count); end
    run_stream("O", 100);
    checks += 3;
    if (set_q.size() != 1 || set_q[0] != 2) begin errors++; $display("FAIL kl_next_setting got=%0d exp=2", set_q.size() ? set_q[0] : -1); end
    if (got_q.size() != 2 || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL kl_next_char got=%h exp=%h", got_q.size() > 1 ? got_q[1] : 8'hxx, exp_q[1]); end
    if (char_count !== 16'd2) begin errors++; $display("FAIL kl_next_count got=%0d exp=2", char_count); end
    exp_q.delete();
    predict("Z");
    held = exp_q[0];
    s_valid = 1; s_char = "Z"; m_ready = 0;
    @(posedge clk); @(negedge clk);
    s_valid = 0; key_in = K1; key_load = 1;
    @(posedge clk); @(negedge clk);
    key_load = 0;
    model_load(K1);
    checks += 2;
    if (m_char !== held || m_valid !== 1'b1) begin errors++; $display("FAIL kl_held got=%h/%b exp=%h/1", m_char, m_valid, held); end
    if (char_count !== 16'd0) begin errors++; $display("FAIL kl_held_count got=%0d exp=0", char_count); end
    run_stream("", 100);
  endtask

  task automatic test_async_reset;
    do_key_load(K1);
    s_valid = 1; s_char = "H"; m_ready = 0;
    @(posedge clk); @(negedge clk);
    s_valid = 0;
    #2 rst_n = 0;
    #1;
    checks += 3;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL ar_m_valid got=%b exp=0", m_valid); end
    if (m_char !== 8'h00) begin errors++; $display("FAIL ar_m_char got=%h exp=00", m_char); end
    if (char_count !== 16'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", char_count); end
    @(negedge clk); rst_n = 1;
    model_load(8'h00);
    exp_q.delete();
    predict("AB");
    run_stream("AB", 100);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin errors++; $display("FAIL ar_zero_key got=%h%h exp=%h%h", got_q.size() > 0 ? got_q[0] : 8'hxx, got_q.size() > 1 ? got_q[1] : 8'hxx, exp_q[0], exp_q[1]); end
  endtask

  task automatic test_lowercase;
`ifdef ENIGMA_LOWERCASE_FOLD_EN
    string e = "CSYQG";
    int ec = 5;
`else
    string e = "hello";
    int ec = 0;
`endif
    do_key_load(K1);
    run_stream("hello", 100);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== e[i]) begin errors++; $display("FAIL lc_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, e[i]); end
    end
    checks++;
    if (char_count !== 16'(ec)) begin errors++; $display("FAIL lc_count got=%0d exp=%0d", char_count, ec); end
  endtask

  task automatic test_random;
    string cs = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcxyz 0!~";
    for (int r = 0; r < 4; r++) begin
      string s = "";
      logic [7:0] k = 8'($urandom_range(255));
      do_key_load(k);
      for (int i = 0; i < 60; i++) begin
        s = {s, " "};
        s[s.len() - 1] = cs[$urandom_range(cs.len() - 1)];
      end
      predict(s);
      proto_err = 0;
      run_stream(s, 30 + 20 * r);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_char[%0d] got=%h exp=%h", i, i < got_q.size() ? got_q[i] : 8'hxx, exp_q[i]); end
      end
      for (int i = 0; i < exp_set.size(); i++) begin
        checks++;
        if (i >= set_q.size() || set_q[i] != exp_set[i]) begin errors++; $display("FAIL rnd_setting[%0d] got=%0d exp=%0d", i, i < set_q.size() ? set_q[i] : -1, exp_set[i]); end
      end
      checks += 2;
      if (char_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", char_count, m_cnt); end
      if (proto_err != 0) begin errors++; $display("FAIL rnd_s_ready got=%0d violations exp=0", proto_err); end
    end
  endtask

  initial begin
    build_tbl();
    test_reset();
    test_encrypt();
    test_decrypt();
    test_back_pressure();
    test_nonletter();
    test_keyload_mid();
    test_async_reset();
    test_lowercase();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/enigma_key_sequencer.md
Name: enigma_key_sequencer

Overview:
- Upstream feeder for the combinational Modified Enigma mapper (8-bit ASCII in/out plus 2-bit setting).
- Accepts a valid/ready stream of ASCII characters and a 4-digit key of 2-bit settings, e.g. key "2103".
- Drives the mapper's char/setting inputs with the key digit rotating once per letter, then registers the mapper result onto a valid/ready output stream.
- Replaces the manual per-character setting entry with a clocked, back-pressured stage.

Parameters:
- CNT_W, default 16: width of the processed-character counter.
- KEY_DIGITS, default 4: number of 2-bit digits in the key; must be a power of two.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- key_in  input  2*KEY_DIGITS  key; digit 0 in the MS bits, so "2103" = 8'b10_01_00_11.
- key_load  input  1  one-cycle pulse: latch key_in and reset the digit index to 0.
- s_valid  input  1  input character valid.
- s_ready  output  1  sequencer can accept a character.
- s_char  input  8  input ASCII character.
- map_char  output  8  character to the mapper's "in".
- map_setting  output  2  setting to the mapper's "setting".
- map_out  input  8  mapper result, combinational from map_char/map_setting.
- m_valid  output  1  encrypted/decrypted character valid.
- m_ready  input  1  downstream accepts the character.
- m_char  output  8  output ASCII character.
- char_count  output  CNT_W  letters processed since reset or key_load.

Behaviour:
- Reset (rst_n=0, asynchronous): key_reg=0, idx=0, m_valid=0, m_char=8'h00, char_count=0.
- Reset mid-transfer discards any held output character; no partial state survives.
- Handshake:
  - s_ready = !m_valid || m_ready.
  - Accept when s_valid && s_ready.
  - Output transfer when m_valid && m_ready.
  - s_valid must hold s_char stable until accepted; m_valid holds m_char stable until m_ready.
- Mapper drive, combinational pass-through:
  - map_char = s_char.
  - map_setting = key_load ? digit0(key_in) : digit idx of key_reg.
- Latency: an accepted character appears on m_char with m_valid=1 on the next cycle. Full throughput of one character per cycle while m_ready=1.
- Letters ('A'..'Z', 8'h41..8'h5A):
  - On accept, m_char <= map_out, idx <= idx+1 (wraps KEY_DIGITS-1 -> 0), char_count <= char_count+1.
  - char_count saturates at all-ones.
- Non-letters: on accept, m_char <= s_char unchanged; idx and char_count unchanged.
- Output register:
  - Accept and no output transfer: m_valid <= 1.
  - Output transfer and no accept: m_valid <= 0.
  - Both in the same cycle: m_valid stays 1 with the new character.
- Output stall (m_valid=1, m_ready=0): s_ready=0, all state frozen.
- key_load:
  - key_reg <= key_in, idx <= 0, char_count <= 0.
  - If a letter is accepted in the same cycle, it uses digit 0 of the new key; afterwards idx=1 and char_count=1.
  - Does not disturb a character already held on m_char.
- Only one state variable beyond the data path: output register full/empty, i.e. m_valid.

Optional Feature:
- Macro: ENIGMA_LOWERCASE_FOLD_EN.
- Defined: 'a'..'z' are folded to uppercase (bit 5 cleared) before driving map_char and treated as letters. Output is always uppercase.
- Undefined: lowercase is a non-letter and passes through unchanged without advancing idx.

Decomposition:
- Shared package enigma_pkg holds:
  - CHAR_W=8, SETTING_W=2.
  - ASCII_A=8'h41, ASCII_Z=8'h5A, ASCII_LA=8'h61, ASCII_LZ=8'h7A.
  - Function is_upper(char).
  - Setting typedef (2-bit).
- One natural sub-module: enigma_out_reg, the 1-deep valid/ready output register holding m_char/m_valid and generating s_ready.

Test Plan:
- Encrypt:
  - key_load with 8'b10_01_00_11, stream "HELLOWORLD", m_ready=1, real mapper attached.
  - Expect map_setting sequence 2,1,0,3,2,1,0,3,2,1.
  - Expect m_char "CSYQGKAHDC" one cycle after each accept; char_count=10.
- Decrypt: after a new key_load with the same key, stream "CSYQGKAHDC" -> m_char "HELLOWORLD".
- Back-pressure:
  - Hold m_ready=0 for 3 cycles after the first output.
  - Expect s_ready=0, m_char stable, idx frozen.
  - On release, the remainder completes with the identical result.
- Non-letter: stream "HE LLO" -> space passes as 8'h20, digit sequence for letters still 2,1,0,3,2, char_count=5.
- key_load asserted on the same cycle as accepting "L" (mid-message) -> that "L" uses digit 0 of the new key, next letter uses digit 1, char_count=1.
- Reset: rst_n low while m_valid=1 -> m_valid=0, m_char=0, char_count=0 immediately, without waiting for a clock edge.
- Feature on: "hello" -> same output as "HELLO".
- Feature off: "hello" passes through unchanged.
